// File: rtl/div_unit.sv
// Sequential signed restoring divider for the DIV instruction: quotient to LO, remainder to HI.
// One quotient bit per clock, then a fix-up cycle applies the MIPS sign rules.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   rem;        // partial remainder, one guard bit for the shift
  logic [WIDTH-1:0] quot;       // dividend magnitude shifts out as quotient bits shift in
  logic [WIDTH-1:0] dvsr;
  logic             dvd_neg;
  logic             dvsr_neg;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvsr_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Magnitudes are read as unsigned, so the negation of -2^(WIDTH-1) yields the correct 2^(WIDTH-1).
  always_comb begin
    dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    dvsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    shifted  = {rem, quot[WIDTH-1]};
    trial    = shifted - {2'b00, dvsr};
  end

  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments and an async reset on every register,
  // so a reset mid-operation clears results at once and no stale done can follow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      dvd_neg  <= 1'b0;
      dvsr_neg <= 1'b0;
      count    <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              quot     <= dvd_mag;
              dvsr     <= dvsr_mag;
              dvd_neg  <= dividend[WIDTH-1];
              dvsr_neg <= divisor[WIDTH-1];
              rem      <= '0;
              count    <= '0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          // Restore by keeping the shifted value whenever the trial subtraction borrows.
          if (!trial[WIDTH+1]) begin
            rem  <= trial[WIDTH:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= shifted[WIDTH:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          lo_out <= (dvd_neg ^ dvsr_neg) ? -quot : quot;
          hi_out <= dvd_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
